neural_param_loader: RTL and testbench

NEURAL_PARAM_LOADER -- requirements
Module: neural_param_loader

---
 rtl/neural_param_loader_pkg.sv | 21 ++
 rtl/neural_param_loader_bank.sv | 28 ++
 rtl/neural_param_loader.sv | 146 ++++++++++++++
 tb/tb_neural_param_loader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neural_param_loader_pkg.sv
// Shared constants for the neural parameter loader: load FSM states and
// parameter word indices.
package neural_param_loader_pkg;

  localparam int unsigned NUM_PARAMS = 6;
  localparam int unsigned IDX_W      = 3;

  localparam logic [IDX_W-1:0] IDX_COEFF11 = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_COEFF12 = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_COEFF21 = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_COEFF22 = IDX_W'(3);
  localparam logic [IDX_W-1:0] IDX_BIAS1   = IDX_W'(4);
  localparam logic [IDX_W-1:0] IDX_BIAS2   = IDX_W'(5);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADING = 2'd1,
    ST_COMMIT  = 2'd2
  } load_state_t;

endpackage

// File: rtl/neural_param_loader_bank.sv
// Six-entry parameter register bank: single indexed write or full parallel
// load, all entries read in parallel.
module neural_param_bank
  import neural_param_loader_pkg::*;
#(
  parameter int unsigned width = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_en,
  input  logic [IDX_W-1:0]                    wr_idx,
  input  logic [width-1:0]                    wr_data,
  input  logic                                ld_en,
  input  logic [NUM_PARAMS-1:0][width-1:0]    ld_data,
  output logic [NUM_PARAMS-1:0][width-1:0]    data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (ld_en) begin
      data <= ld_data;
    end else if (wr_en && (wr_idx <= IDX_BIAS2)) begin
      data[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/neural_param_loader.sv
// Double-buffered parameter loader and two-stage sample pipeline wrapped
// around an external combinational two-neuron layer.
module neural_param_loader
  import neural_param_loader_pkg::*;
#(
  parameter int unsigned width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prm_valid,
  output logic             prm_ready,
  input  logic [width-1:0] prm_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_a,
  input  logic [width-1:0] in_b,
  output logic [width-1:0] lay_inputA,
  output logic [width-1:0] lay_inputB,
  output logic [width-1:0] lay_coeff11,
  output logic [width-1:0] lay_coeff12,
  output logic [width-1:0] lay_coeff21,
  output logic [width-1:0] lay_coeff22,
  output logic [width-1:0] lay_bias1,
  output logic [width-1:0] lay_bias2,
  input  logic [width-1:0] lay_out1,
  input  logic [width-1:0] lay_out2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out1,
  output logic [width-1:0] out2,
  output logic             params_loaded
);

  load_state_t                          state;
  logic [IDX_W-1:0]                     widx;
  logic                                 s1_valid;
  logic                                 prm_fire;
  logic                                 commit_go;
  logic                                 in_fire;
  logic                                 s1_move;
  logic [NUM_PARAMS-1:0][width-1:0]     shadow_data;
  logic [NUM_PARAMS-1:0][width-1:0]     active_data;

  assign prm_fire  = prm_valid && prm_ready;
  // Swap banks only once no sample is in flight in the layer stage.
  assign commit_go = (state == ST_COMMIT) && !s1_valid;
  assign s1_move   = s1_valid && (!out_valid || out_ready);
  assign in_ready  = params_loaded && (state != ST_COMMIT) &&
                     (!s1_valid || !out_valid || out_ready);
  assign in_fire   = in_valid && in_ready;

  neural_param_bank #(.width(width)) u_shadow (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (prm_fire),
    .wr_idx  (widx),
    .wr_data (prm_data),
    .ld_en   (1'b0),
    .ld_data ('0),
    .data    (shadow_data)
  );

  neural_param_bank #(.width(width)) u_active (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (1'b0),
    .wr_idx  ('0),
    .wr_data ('0),
    .ld_en   (commit_go),
    .ld_data (shadow_data),
    .data    (active_data)
  );

  // Load FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      widx          <= '0;
      prm_ready     <= 1'b1;
      params_loaded <= 1'b0;
    end else begin
      if (prm_fire) begin
        widx <= (widx == IDX_BIAS2) ? '0 : widx + IDX_W'(1);
      end
      case (state)
        ST_IDLE: begin
          if (prm_fire) begin
            state <= ST_LOADING;
          end
        end
        ST_LOADING: begin
          if (prm_fire && (widx == IDX_BIAS2)) begin
            state     <= ST_COMMIT;
            prm_ready <= 1'b0;
          end
        end
        ST_COMMIT: begin
          if (commit_go) begin
            state         <= ST_IDLE;
            prm_ready     <= 1'b1;
            params_loaded <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          prm_ready <= 1'b1;
        end
      endcase
    end
  end

  // Sample pipeline: S1 feeds the layer, output stage captures its result.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      lay_inputA <= '0;
      lay_inputB <= '0;
      out_valid  <= 1'b0;
      out1       <= '0;
      out2       <= '0;
    end else begin
      if (in_fire) begin
        s1_valid   <= 1'b1;
        lay_inputA <= in_a;
        lay_inputB <= in_b;
      end else if (s1_move) begin
        s1_valid <= 1'b0;
      end
      if (s1_move) begin
        out_valid <= 1'b1;
        out1      <= lay_out1;
        out2      <= lay_out2;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign lay_coeff11 = active_data[IDX_COEFF11];
  assign lay_coeff12 = active_data[IDX_COEFF12];
  assign lay_coeff21 = active_data[IDX_COEFF21];
  assign lay_coeff22 = active_data[IDX_COEFF22];
  assign lay_bias1   = active_data[IDX_BIAS1];
  assign lay_bias2   = active_data[IDX_BIAS2];

endmodule

// File: tb/tb_neural_param_loader.sv
// Scoreboard bench for neural_param_loader with a behavioural two-neuron layer.
module tb_neural_param_loader;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         prm_valid;
  logic         prm_ready;
  logic [W-1:0] prm_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic [W-1:0] lay_inputA, lay_inputB;
  logic [W-1:0] lay_coeff11, lay_coeff12, lay_coeff21, lay_coeff22;
  logic [W-1:0] lay_bias1, lay_bias2;
  logic [W-1:0] lay_out1, lay_out2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out1, out2;
  logic         params_loaded;

  always #5 clk = ~clk;

  neural_param_loader #(.width(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .prm_valid     (prm_valid),
    .prm_ready     (prm_ready),
    .prm_data      (prm_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .lay_inputA    (lay_inputA),
    .lay_inputB    (lay_inputB),
    .lay_coeff11   (lay_coeff11),
    .lay_coeff12   (lay_coeff12),
    .lay_coeff21   (lay_coeff21),
    .lay_coeff22   (lay_coeff22),
    .lay_bias1     (lay_bias1),
    .lay_bias2     (lay_bias2),
    .lay_out1      (lay_out1),
    .lay_out2      (lay_out2),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out1          (out1),
    .out2          (out2),
    .params_loaded (params_loaded)
  );

  // Layer: plain sum in mode 0, weighted sum plus bias in mode 1.
  logic layer_mode;
  always_comb begin
    if (layer_mode) begin
      lay_out1 = lay_inputA * lay_coeff11 + lay_inputB * lay_coeff12 + lay_bias1;
      lay_out2 = lay_inputA * lay_coeff21 + lay_inputB * lay_coeff22 + lay_bias2;
    end else begin
      lay_out1 = lay_inputA + lay_inputB;
      lay_out2 = lay_inputA + lay_inputB;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [W-1:0] pset [4][6];
  int cur_set  = 0;
  int pend_set = 0;
  bit lat_chk  = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] e1;
    logic [W-1:0] e2;
    int           acc;
  } exp_t;
  exp_t sb[$];

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int s, input logic m);
    exp_t r;
    if (m) begin
      r.e1 = a * pset[s][0] + b * pset[s][1] + pset[s][4];
      r.e2 = a * pset[s][2] + b * pset[s][3] + pset[s][5];
    end else begin
      r.e1 = a + b;
      r.e2 = a + b;
    end
    r.acc = 0;
    return r;
  endfunction

  // Monitor: pushes expectations on sample accept, pops and compares on output.
  int           widx = 0;
  bit           commit_next = 0;
  bit           hold_v = 0;
  logic [W-1:0] h1, h2;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      widx        = 0;
      commit_next = 0;
      hold_v      = 0;
    end else begin
      if (commit_next) begin
        check_eq("inr_commit", 32'(in_ready), 32'(0));
        commit_next = 0;
      end
      if (in_valid && in_ready) begin
        e = model(in_a, in_b, cur_set, layer_mode);
        e.acc = cyc;
        sb.push_back(e);
      end
      if (prm_valid && prm_ready) begin
        if (widx == 5) begin
          widx        = 0;
          cur_set     = pend_set;
          commit_next = 1;
        end else begin
          widx++;
        end
      end
      if (out_valid && out_ready) begin
        check_eq("sb_nonempty", 32'(sb.size() != 0), 32'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_eq("out1", 32'(out1), 32'(e.e1));
          check_eq("out2", 32'(out2), 32'(e.e2));
          if (lat_chk) check_eq("latency", 32'(cyc - e.acc), 32'(2));
        end
      end
      if (out_valid && !out_ready) begin
        if (hold_v) begin
          check_eq("hold1", 32'(out1), 32'(h1));
          check_eq("hold2", 32'(out2), 32'(h2));
        end
        hold_v = 1;
        h1 = out1;
        h2 = out2;
      end else begin
        hold_v = 0;
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit strict);
    int   n = 0;
    logic ok;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 100);
    in_valid = 1'b0;
    if (strict) check_eq("stream_rdy", 32'(n), 32'(1));
    else if (!ok) check_eq("send_timeout", 32'(ok), 32'(1));
  endtask

  task automatic load_set(input int s, input int nw);
    pend_set = s;
    for (int i = 0; i < nw; i++) begin
      int   n = 0;
      logic ok;
      prm_valid = 1'b1;
      prm_data  = pset[s][i];
      do begin
        @(negedge clk);
        ok = prm_ready;
        @(posedge clk);
        #1;
        n++;
      end while (!ok && n < 100);
      if (!ok) check_eq("prm_timeout", 32'(ok), 32'(1));
    end
    prm_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_eq("drain", 32'(sb.size()), 32'(0));
  endtask

  task automatic check_lay(input string tag, input int s);
    logic [W-1:0] lv [6];
    lv = '{lay_coeff11, lay_coeff12, lay_coeff21, lay_coeff22, lay_bias1, lay_bias2};
    for (int i = 0; i < 6; i++)
      check_eq($sformatf("%s_w%0d", tag, i), 32'(lv[i]), 32'(pset[s][i]));
  endtask

  initial begin
    logic [W-1:0] rv [8];
    pset[0] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    pset[1] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0010, 16'h0020};
    pset[2] = '{16'h0003, 16'h0005, 16'h0007, 16'h0002, 16'h0011, 16'h0022};
    pset[3] = '{16'h0101, 16'h0009, 16'h0004, 16'h0006, 16'h0033, 16'h0044};
    rst = 1'b1; prm_valid = 1'b0; prm_data = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b1; layer_mode = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("rst_prm_ready", 32'(prm_ready), 32'(1));
    check_eq("rst_in_ready", 32'(in_ready), 32'(0));
    check_eq("rst_out_valid", 32'(out_valid), 32'(0));
    check_eq("rst_loaded", 32'(params_loaded), 32'(0));
    rv = '{lay_inputA, lay_inputB, lay_coeff11, lay_coeff12,
           lay_coeff21, lay_coeff22, lay_bias1, lay_bias2};
    for (int i = 0; i < 8; i++) check_eq($sformatf("rst_lay%0d", i), 32'(rv[i]), 32'(0));

    // First parameter load
    load_set(1, 6);
    check_eq("loaded_early", 32'(params_loaded), 32'(0));
    check_eq("commit_prm_ready", 32'(prm_ready), 32'(0));
    @(posedge clk); #1;
    check_eq("loaded", 32'(params_loaded), 32'(1));
    check_lay("set1", 1);

    // Back-to-back streaming
    lat_chk = 1;
    for (int k = 0; k < 4; k++) send(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'b1);
    drain();
    lat_chk = 0;

    // Backpressure
    layer_mode = 1'b1;
    out_ready  = 1'b0;
    fork
      for (int k = 0; k < 4; k++) send(W'(k + 1), W'(2 * k + 3), 1'b0);
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("bp_inrdy", 32'(in_ready), 32'(0));
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reload under traffic
    fork
      load_set(2, 6);
      for (int k = 0; k < 10; k++) send(W'(k + 5), W'(k + 9), 1'b0);
    join
    drain();
    check_eq("reload_loaded", 32'(params_loaded), 32'(1));
    check_lay("set2", 2);

    // Reset in the middle of a load
    load_set(3, 3);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cur_set = 0;
    check_eq("midrst_loaded", 32'(params_loaded), 32'(0));
    check_eq("midrst_coeff11", 32'(lay_coeff11), 32'(0));
    load_set(3, 6);
    @(posedge clk); #1;
    check_eq("set3_loaded", 32'(params_loaded), 32'(1));
    check_lay("set3", 3);
    send(W'(7), W'(11), 1'b0);
    send(W'(300), W'(2), 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
